// File: rtl/axi4_stream_rx_fifo.sv
// axi4_stream_rx_fifo: AXI4-Stream sink into a show-ahead FIFO with per-frame byte counting
module axi4_stream_rx_fifo #(
    parameter int BUS_WIDTH = 32,
    parameter int DEPTH = 16,
    parameter int LEN_W = 16,
    localparam int DATA_W = ((BUS_WIDTH-1)/8+1)*8,
    localparam int KEEP_W = DATA_W/8,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    output logic              s_tready,
    input  logic [DATA_W-1:0] s_tdata,
    input  logic [KEEP_W-1:0] s_tkeep,
    input  logic              s_tlast,
    input  logic              s_tvalid,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic [KEEP_W-1:0] rd_keep,
    output logic              rd_last,
    output logic              empty,
    output logic [AW:0]       level,
    output logic              frame_done,
    output logic [LEN_W-1:0]  frame_bytes,
    output logic              frame_ovf
);
    localparam int PW = $clog2(KEEP_W+1);
    logic [DATA_W+KEEP_W:0] mem [DEPTH];
    logic [AW-1:0] wptr, rptr;
    logic [LEN_W-1:0] acc, sat;
    logic [LEN_W:0] sum;
    logic [PW-1:0] pc;
    logic ovf, ovf_n, wr, rd;
    assign s_tready = !rst && (level != (AW+1)'(DEPTH));
    assign empty = level == '0;
    assign wr = s_tvalid && s_tready;
    assign rd = rd_en && !empty;
    assign {rd_last, rd_keep, rd_data} = mem[rptr];
    always_comb begin
        pc = '0;
        for (int i = 0; i < KEEP_W; i++) pc = pc + PW'(s_tkeep[i]);
    end
    assign sum = {1'b0, acc} + (LEN_W+1)'(pc);
    assign sat = sum[LEN_W] ? '1 : sum[LEN_W-1:0];
    assign ovf_n = ovf || sum[LEN_W];
    always_ff @(posedge clk) if (wr) mem[wptr] <= {s_tlast, s_tkeep, s_tdata};
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
            level <= '0;
            acc <= '0;
            ovf <= 1'b0;
            frame_done <= 1'b0;
            frame_bytes <= '0;
            frame_ovf <= 1'b0;
        end else begin
            frame_done <= wr && s_tlast;
            if (wr) wptr <= wptr + 1'b1;
            if (rd) rptr <= rptr + 1'b1;
            level <= level + (AW+1)'(wr) - (AW+1)'(rd);
            if (wr) begin
                acc <= s_tlast ? '0 : sat;
                ovf <= !s_tlast && ovf_n;
                if (s_tlast) begin
                    frame_bytes <= sat;
                    frame_ovf <= ovf_n;
                end
            end
        end
    end
endmodule
